emergency_preempt_arbiter: RTL and testbench

- Arbitrates emergency-vehicle pre-emption requests from N_REQ roadside detectors into the single-direction emergency_NS / emergency_EW inputs of the intersection light controller.
- Debounces each request and grants one requester at a time, round-robin.
- Enforces minimum and maximum pre-emption hold times and an all-clear gap between grants.
- The two emergency outputs are never asserted together.

---
 rtl/emergency_preempt_arbiter.sv | 158 +++++++++++++++
 tb/tb_emergency_preempt_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/emergency_preempt_arbiter.sv
// Emergency pre-emption arbiter: debounces detector requests and grants one at a
// time, round-robin, onto the NS/EW pre-emption inputs with hold limits and a clear gap.
module emergency_preempt_arbiter #(
  parameter int unsigned       N_REQ     = 4,
  parameter logic [N_REQ-1:0]  DIR_MAP   = 4'b1100,
  parameter int unsigned       DEBOUNCE  = 3,
  parameter int unsigned       MIN_HOLD  = 8,
  parameter int unsigned       MAX_HOLD  = 60,
  parameter int unsigned       CLEAR_CYC = 3,
  parameter int unsigned       TW        = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_REQ-1:0]           req,
  output logic                       emergency_NS,
  output logic                       emergency_EW,
  output logic                       grant_valid,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       timeout_pulse
);

  localparam int unsigned IW  = $clog2(N_REQ);
  localparam int unsigned DBW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     hold_q, hold_d;
  logic [TW-1:0]     clr_q, clr_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gid_d;
  logic              gv_d, ns_d, ew_d, to_d;
  logic              lock_set;
  logic              grant_exit;

  logic [DBW-1:0]    db_cnt [N_REQ];
  logic [N_REQ-1:0]  req_db;
  logic [N_REQ-1:0]  lockout;
  logic [N_REQ-1:0]  elig;

  logic              pick_ok;
  logic [IW-1:0]     pick;
  int unsigned       pick_j;

  assign elig = req_db & ~lockout;

  // Per-requester debounce and timeout lockout; a low raw sample clears both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) db_cnt[i] <= '0;
      req_db  <= '0;
      lockout <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req[i]) begin
          db_cnt[i] <= '0;
          req_db[i] <= 1'b0;
        end else if (db_cnt[i] != DBW'(DEBOUNCE)) begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
          if (db_cnt[i] == DBW'(DEBOUNCE - 1)) req_db[i] <= 1'b1;
        end
        if (lock_set && (grant_id == IW'(i))) lockout[i] <= 1'b1;
        else if (!req[i])                      lockout[i] <= 1'b0;
      end
    end
  end

  // Round-robin search upward from the pointer, wrapping.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    pick_j  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pick_j = 32'(ptr_q) + k;
      if (pick_j >= N_REQ) pick_j = pick_j - N_REQ;
      if (!pick_ok && elig[pick_j]) begin
        pick_ok = 1'b1;
        pick    = IW'(pick_j);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    clr_d      = clr_q;
    ptr_d      = ptr_q;
    gid_d      = grant_id;
    gv_d       = grant_valid;
    ns_d       = emergency_NS;
    ew_d       = emergency_EW;
    to_d       = 1'b0;
    lock_set   = 1'b0;
    grant_exit = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && pick_ok) begin
          state_d = GRANT;
          gid_d   = pick;
          gv_d    = 1'b1;
          ns_d    = ~DIR_MAP[pick];
          ew_d    = DIR_MAP[pick];
          hold_d  = '0;
        end
      end
      GRANT: begin
        hold_d = hold_q + TW'(1);
        // Timeout wins over a normal release on the same edge.
        if (hold_q == TW'(MAX_HOLD - 1)) begin
          grant_exit = 1'b1;
          to_d       = 1'b1;
          lock_set   = 1'b1;
        end else if ((hold_q >= TW'(MIN_HOLD - 1)) && !req_db[grant_id]) begin
          grant_exit = 1'b1;
        end
        if (grant_exit) begin
          state_d = CLEAR;
          ns_d    = 1'b0;
          ew_d    = 1'b0;
          gv_d    = 1'b0;
          clr_d   = '0;
          ptr_d   = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
        end
      end
      CLEAR: begin
        clr_d = clr_q + TW'(1);
        if (clr_q == TW'(CLEAR_CYC - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      clr_q         <= '0;
      ptr_q         <= '0;
      grant_id      <= '0;
      grant_valid   <= 1'b0;
      emergency_NS  <= 1'b0;
      emergency_EW  <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      clr_q         <= clr_d;
      ptr_q         <= ptr_d;
      grant_id      <= gid_d;
      grant_valid   <= gv_d;
      emergency_NS  <= ns_d;
      emergency_EW  <= ew_d;
      timeout_pulse <= to_d;
    end
  end

endmodule

// File: tb/tb_emergency_preempt_arbiter.sv
// Scoreboard bench for emergency_preempt_arbiter: directed scenarios push expected
// grant records; a negedge monitor rebuilds each grant and compares.
module tb_emergency_preempt_arbiter;

  localparam logic [3:0] DIR_MAP = 4'b1100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] req = '0;
  logic       emergency_NS, emergency_EW, grant_valid, timeout_pulse;
  logic [1:0] grant_id;

  emergency_preempt_arbiter dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .emergency_NS(emergency_NS), .emergency_EW(emergency_EW),
    .grant_valid(grant_valid), .grant_id(grant_id), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id; int ns; int ew; int start; int len; int to;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc;
  int   to_cnt = 0;
  bit   free_mode = 1'b0;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t cyc=%0d)", nm, act, exp, $time, cyc);
    end
  endtask

  task automatic push(input int id, input int ns, input int ew,
                      input int start, input int len, input int to);
    exp_t e;
    e.id = id; e.ns = ns; e.ew = ew; e.start = start; e.len = len; e.to = to;
    sbq.push_back(e);
  endtask

  // Monitor: per-cycle exclusion checks plus grant record reconstruction.
  bit   in_g = 1'b0;
  exp_t act;
  always @(negedge clk) begin
    chk("mutex", int'(emergency_NS & emergency_EW), 0);
    chk("out_vs_valid", int'(emergency_NS | emergency_EW), int'(grant_valid));
    if (timeout_pulse) to_cnt++;
    if (grant_valid && !in_g) begin
      in_g = 1'b1;
      act.id = int'(grant_id); act.ns = int'(emergency_NS); act.ew = int'(emergency_EW);
      act.start = cyc; act.len = 1; act.to = 0;
    end else if (grant_valid) begin
      act.len++;
    end else if (in_g) begin
      in_g = 1'b0;
      act.to = int'(timeout_pulse);
      if (free_mode) begin
        chk("free_len_range", int'(act.len >= 8 && act.len <= 60), 1);
        chk("free_dir", act.ew, int'(DIR_MAP[act.id[1:0]]));
        chk("free_timeout", act.to, int'(act.len == 60));
      end else if (sbq.size() == 0) begin
        chk("unexpected_grant", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("grant_id", act.id, e.id);
        chk("dir_ns", act.ns, e.ns);
        chk("dir_ew", act.ew, e.ew);
        chk("start_cycle", act.start, e.start);
        chk("hold_len", act.len, e.len);
        chk("timeout", act.to, e.to);
      end
    end
    if (reset) to_cnt = 0;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 5000) begin
      tick();
      guard++;
    end
    if (guard >= 5000) chk("wait_timeout", cyc, c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) tick();
    chk("rst_valid", int'(grant_valid), 0);
    chk("rst_ns", int'(emergency_NS), 0);
    chk("rst_ew", int'(emergency_EW), 0);
    chk("rst_id", int'(grant_id), 0);
    chk("rst_to", int'(timeout_pulse), 0);
    reset = 1'b0;
  endtask

  initial begin
    // Single request on NS: grant after 4 edges, early drop still holds 8.
    do_reset();
    push(0, 1, 0, 4, 8, 0);
    req[0] = 1'b1;
    wait_cyc(6);  req[0] = 1'b0;
    wait_cyc(30);
    chk("sb_empty_single", sbq.size(), 0);

    // Two-cycle glitch never grants.
    do_reset();
    req[2] = 1'b1;
    wait_cyc(2);  req[2] = 1'b0;
    wait_cyc(25);
    chk("glitch_no_grant", int'(in_g), 0);
    chk("sb_empty_glitch", sbq.size(), 0);

    // Tie 0/2: index 0 first, then 2 after a 4-cycle all-low gap.
    do_reset();
    push(0, 1, 0, 4, 8, 0);
    push(2, 0, 1, 16, 8, 0);
    req = 4'b0101;
    wait_cyc(10); req[0] = 1'b0;
    wait_cyc(22); req[2] = 1'b0;
    wait_cyc(40);
    chk("sb_empty_tie", sbq.size(), 0);

    // Held request times out at 60, locks out, re-grants after a low sample.
    do_reset();
    push(3, 0, 1, 4, 60, 1);
    push(3, 0, 1, 105, 8, 0);
    req[3] = 1'b1;
    wait_cyc(100);
    chk("timeout_pulse_count", to_cnt, 1);
    chk("no_regrant_locked", int'(grant_valid), 0);
    req[3] = 1'b0;
    wait_cyc(101); req[3] = 1'b1;
    wait_cyc(107); req[3] = 1'b0;
    wait_cyc(130);
    chk("sb_empty_timeout", sbq.size(), 0);
    chk("timeout_pulse_total", to_cnt, 1);

    // Random NS/EW overlap: exclusion and hold bounds only.
    do_reset();
    free_mode = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      tick();
      if ($urandom_range(0, 19) == 0) req[1] = ~req[1];
      if ($urandom_range(0, 19) == 0) req[2] = ~req[2];
    end
    req = '0;
    repeat (80) tick();
    free_mode = 1'b0;

    // Reset during an EW grant drops outputs at once; pointer restarts at 0.
    do_reset();
    push(3, 0, 1, 4, 7, 0);
    push(0, 1, 0, 4, 8, 0);
    req[3] = 1'b1;
    wait_cyc(2);  req[0] = 1'b1;
    wait_cyc(10);
    chk("pre_reset_ew", int'(emergency_EW), 1);
    reset = 1'b1;
    #1;
    chk("async_rst_ew", int'(emergency_EW), 0);
    chk("async_rst_valid", int'(grant_valid), 0);
    req[3] = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    wait_cyc(6);  req[0] = 1'b0;
    wait_cyc(30);
    chk("sb_empty_reset", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
